axi_sram_slave: RTL and testbench
=================================

// Module: axi_sram_slave
// PURPOSE
// AXI3 responder: word-wide on-chip SRAM that answers the burst traffic issued by the I/D-cache AXI arbiter.
// Independent read and write engines, each one outstanding burst, INCR beats of 32 bits.
// Used as the memory end of the cache/arbiter path in simulation and in FPGA bring-up without external DRAM.
// PARAMETERS
// IDX_W    10   word-index width; DEPTH = 2**IDX_W words; byte address bits [IDX_W+1:2] select the word
// ID_W     4    AXI ID width (arid/rid, awid/bid)
// PORTS
// clk      in   1     clock; all logic on rising edge
// rst      in   1     synchronous reset, active high
// arid     in   ID_W  read burst ID
// araddr   in   32    read start byte address
// arlen    in   4     beats-1 (0..15)
// arsize   in   3     ignored; every beat is one 32-bit word
// arburst  in   2     ignored; every burst is INCR
// arvalid  in   1     read address valid
// arready  out  1     read address ready
// rid      out  ID_W  echoes the captured arid
// rdata    out  32    read data
// rresp    out  2     always 2'b00 OKAY
// rlast    out  1     final beat of burst
// rvalid   out  1     read data valid
// rready   in   1     read data ready
// awid     in   ID_W  write burst ID
// awaddr   in   32    write start byte address
// awlen    in   4     beats-1
// awsize   in   3     ignored
// awburst  in   2     ignored; INCR
// awvalid  in   1     write address valid
// awready  out  1     write address ready
// wdata    in   32    write data
// wstrb    in   4     byte enables; wstrb[i] writes wdata[8i+7:8i]
// wlast    in   1     final write beat marker
// wvalid   in   1     write data valid
// wready   out  1     write data ready
// bid      out  ID_W  echoes the captured awid
// bresp    out  2     2'b00 OKAY, 2'b10 SLVERR on wlast mismatch
// bvalid   out  1     write response valid
// bready   in   1     write response ready
// BEHAVIOUR
// Reset: both FSMs -> IDLE, beat counters 0, rvalid/rlast/wready/bvalid=0, rdata=0, rid/bid=0; memory retained.
// Reset mid-burst abandons the burst: no further beats, no response. arready/awready=1 in first cycle after rst falls.
// Read FSM R_IDLE -> R_DATA: arready=(state==R_IDLE). On arvalid&arready latch arid, index=araddr[IDX_W+1:2], len, cnt=0;
//   same edge rdata<=mem[index]; rvalid=1 from next cycle (1-cycle latency AR->first R).
// R_DATA: rlast=(cnt==len). On rvalid&rready: if rlast -> R_IDLE, rvalid=0; else cnt++, index++, rdata<=mem[index+1].
//   rvalid held with stable rdata/rlast/rid while rready=0. Back-to-back: next AR accepted the cycle after rlast handshake.
// Write FSM W_IDLE -> W_DATA -> W_RESP: awready=(state==W_IDLE); on handshake latch awid, index, len, cnt=0.
// W_DATA: wready=1. Each wvalid&wready writes mem[index] per wstrb, index++, cnt++. Terminates on cnt==len beat,
//   regardless of wlast; bresp=SLVERR if wlast!=(cnt==len) on any beat, else OKAY. W beats before AW handshake are stalled (wready=0).
// W_RESP: bvalid=1 until bready, then W_IDLE.
// Index arithmetic modulo DEPTH: burst crossing the top word wraps to word 0; araddr/awaddr bits [1:0] and above IDX_W+1 ignored.
// Same-cycle read and write of one word: rdata captures the old value; write visible to subsequent beats/bursts.
// Read and write engines fully concurrent; no ordering between them.
// TESTING
// Write AW addr 0x40 len 3, W 0x11111111..0x44444444 strb 4'hF wlast on 4th -> bvalid, bresp=00, bid=awid.
// Read AR id 1 addr 0x40 len 3, rready=1 -> rvalid 1 cycle after AR, rdata 0x11111111..0x44444444, rlast on beat 4, rid=1.
// Partial strobe: write 0xAABBCCDD strb 4'b0101 over 0x11111111 -> readback 0x11BB11DD.
// rready toggled 1/0 each cycle during len=7 read -> 8 beats, data stable while stalled, no beat dropped or duplicated.
// wlast asserted on beat 2 of len=3 burst -> 4 beats accepted, bresp=2'b10; awaddr at top word len=1 -> second beat to word 0.
// rst pulsed mid read burst -> rvalid=0 next cycle, arready=1 after release, new burst returns correct data.

Source files
------------

// File: rtl/axi_sram_slave_if.sv
// AXI3 bus bundle between the cache arbiter (master) and the on-chip SRAM responder (slave).
interface axi_sram_slave_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [3:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [3:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rresp, rlast, rvalid,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi_sram_slave.sv
// Word-wide SRAM answering AXI3 INCR bursts; independent read and write engines, one burst each.
//   state  | meaning
//   R_IDLE | waiting for AR handshake
//   R_DATA | presenting read beats until the rlast handshake
//   W_IDLE | waiting for AW handshake
//   W_DATA | accepting write beats until cnt==len
//   W_RESP | holding bvalid until bready
module axi_sram_slave #(
  parameter int IDX_W = 10,
  parameter int ID_W  = 4
) (
  input logic               clk,
  input logic               rst,
  axi_sram_slave_if.slave   bus
);
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [31:0] mem [DEPTH];

  r_state_t        r_state, r_next;
  logic [ID_W-1:0] rid_q;
  logic [IDX_W-1:0] r_idx, r_idx_nxt, ar_idx;
  logic [3:0]      r_len, r_cnt;
  logic [31:0]     rdata_q;
  logic            arready_c, rvalid_c, rlast_c, ar_hs, r_hs;

  w_state_t        w_state, w_next;
  logic [ID_W-1:0] bid_q;
  logic [IDX_W-1:0] w_idx, aw_idx;
  logic [3:0]      w_len, w_cnt;
  logic            w_err, w_final;
  logic            awready_c, wready_c, bvalid_c, aw_hs, w_hs;

  assign ar_idx    = bus.araddr[IDX_W+1:2];
  assign aw_idx    = bus.awaddr[IDX_W+1:2];
  assign r_idx_nxt = r_idx + 1'b1;
  assign ar_hs     = bus.arvalid && arready_c;
  assign r_hs      = rvalid_c && bus.rready;
  assign aw_hs     = bus.awvalid && awready_c;
  assign w_hs      = bus.wvalid && wready_c;
  assign w_final   = (w_cnt == w_len);

  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && rlast_c) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    arready_c = (r_state == R_IDLE);
    rvalid_c  = (r_state == R_DATA);
    rlast_c   = rvalid_c && (r_cnt == r_len);
  end

  // Read data is fetched one edge ahead of the beat it belongs to, so a write
  // landing on the same word in that cycle is seen only by later beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      rid_q   <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      rdata_q <= '0;
    end else if (ar_hs) begin
      rid_q   <= bus.arid;
      r_idx   <= ar_idx;
      r_len   <= bus.arlen;
      r_cnt   <= '0;
      rdata_q <= mem[ar_idx];
    end else if (r_hs && !rlast_c) begin
      r_idx   <= r_idx_nxt;
      r_cnt   <= r_cnt + 1'b1;
      rdata_q <= mem[r_idx_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_final) w_next = W_RESP;
      W_RESP:  if (bus.bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    awready_c = (w_state == W_IDLE);
    wready_c  = (w_state == W_DATA);
    bvalid_c  = (w_state == W_RESP);
  end

  // Burst length comes from awlen alone; wlast is only checked for agreement.
  always_ff @(posedge clk) begin
    if (rst) begin
      bid_q <= '0;
      w_idx <= '0;
      w_len <= '0;
      w_cnt <= '0;
      w_err <= 1'b0;
    end else if (aw_hs) begin
      bid_q <= bus.awid;
      w_idx <= aw_idx;
      w_len <= bus.awlen;
      w_cnt <= '0;
      w_err <= 1'b0;
    end else if (w_hs) begin
      w_idx <= w_idx + 1'b1;
      w_cnt <= w_cnt + 1'b1;
      w_err <= w_err | (bus.wlast != w_final);
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wstrb[i]) mem[w_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  assign bus.arready = arready_c;
  assign bus.rvalid  = rvalid_c;
  assign bus.rlast   = rlast_c;
  assign bus.rid     = rid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = 2'b00;
  assign bus.awready = awready_c;
  assign bus.wready  = wready_c;
  assign bus.bvalid  = bvalid_c;
  assign bus.bid     = bid_q;
  assign bus.bresp   = w_err ? 2'b10 : 2'b00;

  logic unused_bus;
  assign unused_bus = ^{bus.araddr[31:IDX_W+2], bus.araddr[1:0],
                        bus.awaddr[31:IDX_W+2], bus.awaddr[1:0],
                        bus.arsize, bus.arburst, bus.awsize, bus.awburst};
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: bursts, strobes, backpressure, wlast mismatch, wrap, reset.
module tb_axi_sram_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic        wl [16];
  logic [31:0] re [16];

  axi_sram_slave_if #(.ID_W(4)) aif ();

  axi_sram_slave #(.IDX_W(10), .ID_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (aif.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] exp_resp);
    int cyc;
    aif.awid    = id;
    aif.awaddr  = addr;
    aif.awlen   = len[3:0];
    aif.awvalid = 1'b1;
    chk("awready", {31'b0, aif.awready}, 32'd1);
    @(negedge clk);
    aif.awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      aif.wvalid = 1'b1;
      aif.wdata  = wd[b];
      aif.wstrb  = ws[b];
      aif.wlast  = wl[b];
      cyc = 0;
      while (!aif.wready && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      chk($sformatf("wready[%0d]", b), {31'b0, aif.wready}, 32'd1);
      @(negedge clk);
    end
    aif.wvalid = 1'b0;
    aif.wlast  = 1'b0;
    cyc = 0;
    while (!aif.bvalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("bvalid", {31'b0, aif.bvalid}, 32'd1);
    chk("bresp", {30'b0, aif.bresp}, {30'b0, exp_resp});
    chk("bid", {28'b0, aif.bid}, {28'b0, id});
    aif.bready = 1'b1;
    @(negedge clk);
    aif.bready = 1'b0;
    chk("bvalid_clr", {31'b0, aif.bvalid}, 32'd0);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input bit toggle);
    int cyc;
    int beat;
    aif.arid    = id;
    aif.araddr  = addr;
    aif.arlen   = len[3:0];
    aif.arvalid = 1'b1;
    chk("arready", {31'b0, aif.arready}, 32'd1);
    @(negedge clk);
    aif.arvalid = 1'b0;
    beat = 0;
    cyc  = 0;
    while (beat <= len && cyc < 64) begin
      aif.rready = toggle ? cyc[0] : 1'b1;
      chk($sformatf("rvalid[%0d]", beat), {31'b0, aif.rvalid}, 32'd1);
      chk($sformatf("rdata[%0d]", beat), aif.rdata, re[beat]);
      chk($sformatf("rlast[%0d]", beat), {31'b0, aif.rlast}, {31'b0, beat == len});
      chk($sformatf("rid[%0d]", beat), {28'b0, aif.rid}, {28'b0, id});
      if (aif.rvalid && aif.rready) beat++;
      @(negedge clk);
      cyc++;
    end
    aif.rready = 1'b0;
    chk("read_done", beat, len + 1);
    chk("rvalid_clr", {31'b0, aif.rvalid}, 32'd0);
  endtask

  initial begin
    aif.arid = '0; aif.araddr = '0; aif.arlen = '0; aif.arsize = 3'd2; aif.arburst = 2'b01;
    aif.arvalid = 1'b0; aif.rready = 1'b0;
    aif.awid = '0; aif.awaddr = '0; aif.awlen = '0; aif.awsize = 3'd2; aif.awburst = 2'b01;
    aif.awvalid = 1'b0; aif.wdata = '0; aif.wstrb = '0; aif.wlast = 1'b0; aif.wvalid = 1'b0;
    aif.bready = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_arready", {31'b0, aif.arready}, 32'd1);
    chk("rst_awready", {31'b0, aif.awready}, 32'd1);
    chk("rst_rvalid", {31'b0, aif.rvalid}, 32'd0);
    chk("rst_rlast", {31'b0, aif.rlast}, 32'd0);
    chk("rst_wready", {31'b0, aif.wready}, 32'd0);
    chk("rst_bvalid", {31'b0, aif.bvalid}, 32'd0);
    chk("rst_rdata", aif.rdata, 32'd0);
    chk("rst_rid", {28'b0, aif.rid}, 32'd0);
    chk("rst_bid", {28'b0, aif.bid}, 32'd0);

    // W presented before any AW must be stalled
    aif.wvalid = 1'b1;
    aif.wdata  = 32'hDEADBEEF;
    aif.wstrb  = 4'hF;
    @(negedge clk);
    chk("w_before_aw", {31'b0, aif.wready}, 32'd0);
    aif.wvalid = 1'b0;

    wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333; wd[3] = 32'h44444444;
    for (int i = 0; i < 4; i++) begin ws[i] = 4'hF; wl[i] = (i == 3); end
    do_write(4'd5, 32'h40, 3, 2'b00);

    re[0] = 32'h11111111; re[1] = 32'h22222222; re[2] = 32'h33333333; re[3] = 32'h44444444;
    do_read(4'd1, 32'h40, 3, 1'b0);

    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101; wl[0] = 1'b1;
    do_write(4'd2, 32'h40, 0, 2'b00);
    re[0] = 32'h11BB11DD;
    do_read(4'd3, 32'h40, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      wd[i] = 32'hA0000000 + i;
      ws[i] = 4'hF;
      wl[i] = (i == 7);
      re[i] = 32'hA0000000 + i;
    end
    do_write(4'd6, 32'h100, 7, 2'b00);
    do_read(4'd7, 32'h100, 7, 1'b1);

    wd[0] = 32'hD0000001; wd[1] = 32'hD0000002; wd[2] = 32'hD0000003; wd[3] = 32'hD0000004;
    for (int i = 0; i < 4; i++) begin ws[i] = 4'hF; wl[i] = (i == 1); end
    do_write(4'd8, 32'h200, 3, 2'b10);
    re[0] = 32'hD0000001; re[1] = 32'hD0000002; re[2] = 32'hD0000003; re[3] = 32'hD0000004;
    do_read(4'd9, 32'h200, 3, 1'b0);

    wd[0] = 32'hC0FFEE01; wd[1] = 32'hC0FFEE02;
    ws[0] = 4'hF; ws[1] = 4'hF; wl[0] = 1'b0; wl[1] = 1'b1;
    do_write(4'hA, 32'hFFC, 1, 2'b00);
    re[0] = 32'hC0FFEE02;
    do_read(4'hB, 32'h0, 0, 1'b0);
    re[0] = 32'hC0FFEE01; re[1] = 32'hC0FFEE02;
    do_read(4'hC, 32'h1000_0FFE, 1, 1'b0);

    // reset in the middle of a stalled read burst
    aif.arid = 4'd4; aif.araddr = 32'h40; aif.arlen = 4'd3; aif.arvalid = 1'b1;
    @(negedge clk);
    aif.arvalid = 1'b0;
    chk("mid_rvalid", {31'b0, aif.rvalid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rvalid", {31'b0, aif.rvalid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_arready", {31'b0, aif.arready}, 32'd1);
    chk("post_rst_rvalid", {31'b0, aif.rvalid}, 32'd0);
    re[0] = 32'h11BB11DD; re[1] = 32'h22222222;
    do_read(4'hD, 32'h40, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
